// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Imported by the transmitter top and its byte FIFO.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int UART_DATA_BITS          = 8;
   localparam int CLKS_PER_BIT_25M_115200 = 217;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic [WIDTH-1:0]                 push_data,
   input  logic                             pop,
   output logic [WIDTH-1:0]                 pop_data,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             full,
   output logic                             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      fill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   assign fill     = wr_ptr - rd_ptr;
   assign count    = CW'(fill);
   assign full     = (fill == (AW+1)'(DEPTH));
   assign empty    = (wr_ptr == rd_ptr);
   assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and valid/ready handshake.
// Line, busy and done are registered from the current state, so they trail the FSM by one clock.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_25M_115200,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [7:0]                         tx_data_i,
   input  logic                               tx_valid_i,
   output logic                               tx_ready_o,
   output logic                               UART_TX_o,
   output logic                               tx_busy_o,
   output logic                               tx_done_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

   tx_state_t                   state;
   logic [CNT_W-1:0]            clk_cnt;
   logic [2:0]                  bit_idx;
   logic [UART_DATA_BITS-1:0]   shift;
   logic                        bit_end;
   logic                        push;
   logic                        pop;
   logic [UART_DATA_BITS-1:0]   fifo_data;
   logic                        fifo_full;
   logic                        fifo_empty;

   assign bit_end    = (clk_cnt == CNT_LAST);
   assign push       = tx_valid_i && !fifo_full;
   assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
   assign tx_ready_o = !fifo_full;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (tx_data_i),
      .pop       (pop),
      .pop_data  (fifo_data),
      .count     (fifo_count_o),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Frame sequencer; a byte waiting at the end of STOP goes straight to START with no idle gap.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         UART_TX_o <= 1'b1;
         tx_busy_o <= 1'b0;
         tx_done_o <= 1'b0;
      end else begin
         UART_TX_o <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
         tx_busy_o <= (state != IDLE);
         tx_done_o <= (state == STOP) && bit_end;

         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (!fifo_empty) begin
                  shift <= fifo_data;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  shift   <= shift >> 1;
                  if (bit_idx == BIT_LAST) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  if (!fifo_empty) begin
                     shift <= fifo_data;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               clk_cnt <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a frame-level model predicts when each byte hits the line,
// decodes the serial output mid-bit, and tracks FIFO occupancy from accept/start times.
module tb_uart_tx;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int BOUND = 20 * FRAME;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          tx_line;
   logic          tx_busy;
   logic          tx_done;
   logic [CW-1:0] fifo_count;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .tx_data_i    (tx_data),
      .tx_valid_i   (tx_valid),
      .tx_ready_o   (tx_ready),
      .UART_TX_o    (tx_line),
      .tx_busy_o    (tx_busy),
      .tx_done_o    (tx_done),
      .fifo_count_o (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc = 0;
   int         last_start = -100000;
   int         nxt_start;
   int         n_vec = 0;
   int         n_miss = 0;
   bit         mon_active = 1'b0;
   int         mon_start = 0;
   logic [7:0] mon_data;
   int         off;
   int         k;
   int         model_count;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Each accepted byte goes on air 2 clocks after acceptance, or right after the previous frame.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         exp_q.delete();
         last_start = -100000;
      end else if (tx_valid && tx_ready) begin
         nxt_start  = (cyc + 2 > last_start + FRAME) ? cyc + 2 : last_start + FRAME;
         last_start = nxt_start;
         exp_q.push_back('{tx_data, nxt_start});
      end
   end

   // Serial decoder plus per-cycle checks of busy, done, count and ready.
   always @(negedge clk) begin
      if (rst) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && tx_line === 1'b0) begin
            mon_active = 1'b1;
            mon_start  = cyc;
            mon_data   = 8'h00;
            if (exp_q.size() == 0) checkOutput("spurious_start", cyc, 32'hFFFF_FFFF);
            else                   checkOutput("start_cycle", cyc, exp_q[0].start);
         end
         off = mon_active ? cyc - mon_start : 0;
         if (mon_active && (off % CPB) == CPB / 2) begin
            k = off / CPB;
            if (k == 0) begin
               checkOutput("start_bit", tx_line, 0);
            end else if (k <= 8) begin
               mon_data[k-1] = tx_line;
            end else begin
               checkOutput("stop_bit", tx_line, 1);
               if (exp_q.size() > 0) begin
                  checkOutput("rx_byte", mon_data, exp_q[0].data);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (!mon_active) checkOutput("idle_line", tx_line, 1);
         checkOutput("busy", tx_busy, mon_active);
         checkOutput("done", tx_done, (mon_active && off == FRAME - 1));
         model_count = 0;
         foreach (exp_q[i]) if (exp_q[i].start - 1 > cyc) model_count++;
         checkOutput("fifo_count", fifo_count, model_count);
         checkOutput("ready", tx_ready, model_count < DEPTH);
         if (mon_active && off == FRAME - 1) mon_active = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      int w;
      w        = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && w < BOUND) begin
         @(negedge clk);
         w++;
      end
      if (w >= BOUND) checkOutput("ready_timeout", w, 0);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || mon_active) && w < BOUND) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (w >= BOUND) checkOutput("idle_timeout", w, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst_line", tx_line, 1);
      checkOutput("rst_ready", tx_ready, 1);
      checkOutput("rst_busy", tx_busy, 0);
      checkOutput("rst_done", tx_done, 0);
      checkOutput("rst_count", fifo_count, 0);
      #2 rst = 1'b0;
      @(negedge clk);

      applyStimulus(8'h55);
      waitIdle();

      applyStimulus(8'hA5);
      applyStimulus(8'h3C);
      waitIdle();

      for (int i = 0; i < 6; i++) applyStimulus(8'(8'h10 + i));
      waitIdle();

      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      applyStimulus(8'h81);
      applyStimulus(8'h7E);
      waitIdle();

      // Reset in the middle of bit 3 of 0x00 with a second byte still queued.
      applyStimulus(8'h00);
      applyStimulus(8'h5A);
      repeat (4 * CPB + 3) @(negedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      last_start = -100000;
      mon_active = 1'b0;
      #1;
      checkOutput("midrst_line", tx_line, 1);
      checkOutput("midrst_count", fifo_count, 0);
      checkOutput("midrst_busy", tx_busy, 0);
      checkOutput("midrst_ready", tx_ready, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3 * FRAME) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
      end
      waitIdle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter: the outbound counterpart to the Pong design's UART receiver. It accepts bytes on a valid/ready handshake, buffers them in a small FIFO, and serializes each one as 8N1 (1 start, 8 data LSB-first, 1 stop) at `CLKS_PER_BIT` clocks per bit. The game top uses it to report score/state back to the host at 115200 baud from the 25 MHz VGA clock.

## Interface
- `CLKS_PER_BIT`, 217: clocks per bit (25 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of 2 and ≥ 2.

- `clk_i` in 1: system clock (25 MHz).
- `rst_i` in 1: reset, asynchronous, active-high.
- `tx_data_i` in 8: byte to send.
- `tx_valid_i` in 1: `tx_data_i` is valid.
- `tx_ready_o` out 1: FIFO can accept; equals !full.
- `UART_TX_o` out 1: serial line; idle high.
- `tx_busy_o` out 1: a frame is on the line.
- `tx_done_o` out 1: one-cycle pulse at the end of each stop bit.
- `fifo_count_o` out $clog2(FIFO_DEPTH+1): bytes waiting, not counting the one in flight.

## Operation
- **Handshake.** A byte is accepted on a rising edge where `tx_valid_i && tx_ready_o`, and is written to the FIFO. `tx_valid_i` while not ready is ignored; nothing is lost, because the source holds.
- **FSM states.** IDLE, START, DATA, STOP.
  - IDLE: when FIFO is non-empty, pop into an 8-bit shift register and go to START.
  - START: line 0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: line = shift[0]; after each CLKS_PER_BIT clocks, shift right. After bit index 7, go to STOP.
  - STOP: line 1 for CLKS_PER_BIT clocks. At the last clock, pulse `tx_done_o`. If FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Counters.**
  - Clock counter runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It clears on every state change and on every bit boundary.
  - Bit index runs 0..7, 3 bits.
- **`UART_TX_o`** is registered. It is 1 in IDLE and STOP, 0 in START, and shift[0] in DATA.
- **`tx_busy_o`** is 1 in START, DATA and STOP.
- **FIFO full.** `tx_ready_o` is derived from the registered count. With the FIFO full, a pop in the same cycle does not raise ready until the next cycle.
- **FIFO empty.** There is no bypass. A push into an empty FIFO is popped on the following edge.
- **Simultaneous push and pop** (FIFO non-empty, not full): count is unchanged, and the data ordering is preserved.

## Timing
- **Reset values.** `UART_TX_o`=1, `tx_ready_o`=1, `tx_busy_o`=0, `tx_done_o`=0, `fifo_count_o`=0. FSM is in IDLE and the FIFO is empty.
- **Latency.** Byte accepted at edge N with the FSM idle and FIFO empty:
  - Pop at edge N+1, so `UART_TX_o`=0 after edge N+2.
  - Frame occupies exactly 10·CLKS_PER_BIT clocks.
  - `tx_done_o` is high during the frame's last clock.
- **Back-to-back bytes.** The next start bit begins on the clock immediately after the previous stop bit's last clock.
- **Reset mid-frame.** The line goes high immediately (asynchronous), the FIFO is flushed, and the partial byte is discarded. There is no glitch low after reset release.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE/START/DATA/STOP).
  - `UART_DATA_BITS`=8.
  - Default `CLKS_PER_BIT_25M_115200`=217.
- Sub-module `uart_tx_fifo`: synchronous FIFO (`DEPTH` parameter).
  - Pointers one bit wider than the address, for full/empty detection.
  - Outputs `count`, `full`, `empty`.
  - Same clock and asynchronous reset as the parent.
- The top holds the FSM, counters and shift register.

## Test plan
- **Single byte.** Send 0x55 with CLKS_PER_BIT=217 → line 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop). Each bit is 217 clocks. Start edge is 2 clocks after acceptance; one `tx_done_o` pulse arrives 2170 clocks after the start edge.
- **Back-to-back.** Push 0xA5 then 0x3C on consecutive cycles → two frames with zero idle clocks between stop(0xA5) and start(0x3C), and two `tx_done_o` pulses 2170 clocks apart.
- **Full FIFO.** CLKS_PER_BIT=4, push 6 bytes continuously → 1 is popped and 4 are buffered. `tx_ready_o` drops with `fifo_count_o`=4, and the 6th byte is held until ready returns one cycle after the next pop. All 6 bytes are transmitted in order.
- **Reset mid-frame.** Assert `rst_i` during DATA bit 3 of 0x00 → `UART_TX_o`=1 before the next clock edge, and `fifo_count_o`=0. After release, the line stays high with no spurious frame.
- **Loopback.** CLKS_PER_BIT=8, connect `UART_TX_o` to the existing UART receiver at the same rate and send 0x00, 0xFF, 0x81, 0x7E → the receiver reports the same four bytes, and `tx_busy_o` deasserts after the last `tx_done_o`.
